// File: rtl/lot_lane_arbiter.sv
// Two-lane occupancy arbiter for the parking-lot counter.
// Each lane's enter/exit pulses are latched into one pending flag per slot.
// A round-robin pointer picks at most one pending event per cycle. The chosen
// event is either committed as a single inc/dec pulse or refused at the
// capacity/empty limit. The block keeps its own registered copy of the count
// together with its status flags.
module lot_lane_arbiter #(
    parameter int CAPACITY = 5,
    parameter int CW       = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enter0,
    input  logic          exit0,
    input  logic          enter1,
    input  logic          exit1,
    output logic          inc,
    output logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic [1:0]    gate_ok,
    output logic [1:0]    reject,
    output logic          overflow
);

    localparam logic [CW-1:0] CAP_C  = CW'(CAPACITY);
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    // Slot order is fixed: 0=enter0, 1=exit0, 2=enter1, 3=exit1.
    // Bit 0 of a slot index selects exit, and bit 1 selects the lane.
    logic [3:0]    pulse_s;
    logic [3:0]    pend_q, pend_d;
    logic [1:0]    ptr_q, ptr_d;
    logic          inc_q, inc_d;
    logic          dec_q, dec_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic [1:0]    rej_q, rej_d;
    logic          ovf_q, ovf_d;

    logic          win_valid_s;
    logic [1:0]    win_s;
    logic [1:0]    idx_s;
    logic [3:0]    clr_s;
    logic [3:0]    keep_s;

    assign pulse_s = {exit1, enter1, exit0, enter0};

    // Round-robin search from the pointer, wrapping 3->0; the first pending slot wins.
    always_comb begin
        win_valid_s = 1'b0;
        win_s       = 2'd0;
        idx_s       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx_s = ptr_q + 2'(k);
            if (!win_valid_s && pend_q[idx_s]) begin
                win_valid_s = 1'b1;
                win_s       = idx_s;
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    // Next state: the granted flag is consumed, new pulses are captured, and the count is updated within limits.
    always_comb begin
        clr_s   = win_valid_s ? (4'b0001 << win_s) : 4'b0000;
        keep_s  = pend_q & ~clr_s;
        // A slot that is granted this cycle may be re-armed by its own new pulse.
        pend_d  = keep_s | pulse_s;
        ovf_d   = ovf_q | (|(pulse_s & keep_s));
        ptr_d   = ptr_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        rej_d   = 2'b00;
        cnt_d   = cnt_q;
        if (win_valid_s) begin
            ptr_d = win_s + 2'd1;
            if (!win_s[0]) begin
                if (cnt_q != CAP_C) begin
                    inc_d = 1'b1;
                    cnt_d = cnt_q + ONE_C;
                end else begin
                    rej_d[win_s[1]] = 1'b1;
                end
            end else begin
                if (cnt_q != ZERO_C) begin
                    dec_d = 1'b1;
                    cnt_d = cnt_q - ONE_C;
                end else begin
                    rej_d[win_s[1]] = 1'b1;
                end
            end
        end else begin
            ptr_d = ptr_q;
        end
        full_d  = (cnt_d == CAP_C);
        empty_d = (cnt_d == ZERO_C);
    end

    // State and output registers. Reset is synchronous and active-low, and it overrides every same-cycle input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q  <= 4'b0000;
            ptr_q   <= 2'd0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            cnt_q   <= ZERO_C;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            rej_q   <= 2'b00;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            rej_q   <= rej_d;
            ovf_q   <= ovf_d;
        end
    end

    assign inc      = inc_q;
    assign dec      = dec_q;
    assign count    = cnt_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign gate_ok  = {2{~full_q}};
    assign reject   = rej_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_lot_lane_arbiter.sv
// Randomized and directed bench for lot_lane_arbiter with a behavioural lot model.
module tb_lot_lane_arbiter;

    localparam int CAP = 5;
    localparam int CW  = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enter0 = 1'b0, exit0 = 1'b0, enter1 = 1'b0, exit1 = 1'b0;
    logic          inc, dec, full, empty, overflow;
    logic [CW-1:0] count;
    logic [1:0]    gate_ok, reject;

    int n_checks = 0;
    int n_err    = 0;

    lot_lane_arbiter #(.CAPACITY(CAP), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .enter0(enter0), .exit0(exit0), .enter1(enter1), .exit1(exit1),
        .inc(inc), .dec(dec), .count(count), .full(full), .empty(empty),
        .gate_ok(gate_ok), .reject(reject), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: one pending request per event kind plus a rotating start position.
    bit m_pend[4];
    int m_ptr, m_cnt;
    bit m_inc, m_dec, m_ovf;
    bit [1:0] m_rej;

    function automatic void model_step(bit e0, bit x0, bit e1, bit x1, bit rst);
        bit p[4];
        int w;
        p = '{e0, x0, e1, x1};
        m_inc = 0; m_dec = 0; m_rej = 0;
        if (!rst) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_ptr = 0; m_cnt = 0; m_ovf = 0;
            return;
        end
        w = -1;
        for (int k = 0; k < 4; k++)
            if (w < 0 && m_pend[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        if (w >= 0) begin
            m_pend[w] = 0;
            m_ptr = (w + 1) % 4;
            if (w % 2 == 0) begin
                if (m_cnt < CAP) begin m_cnt++; m_inc = 1; end
                else m_rej[w / 2] = 1'b1;
            end else begin
                if (m_cnt > 0) begin m_cnt--; m_dec = 1; end
                else m_rej[w / 2] = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++)
            if (p[i]) begin
                if (m_pend[i]) m_ovf = 1;
                else m_pend[i] = 1;
            end
    endfunction

    function automatic logic [15:0] exp_vec();
        logic f;
        f = (m_cnt == CAP);
        return {m_inc, m_dec, 7'(m_cnt), f, (m_cnt == 0), (f ? 2'b00 : 2'b11), m_rej, m_ovf};
    endfunction

    logic [15:0] obs;
    assign obs = {inc, dec, count, full, empty, gate_ok, reject, overflow};

    // One clock: drive inputs at the negedge, advance the model at the posedge, and return at the next negedge.
    task automatic tick(input bit e0, x0, e1, x1, input bit rst = 1'b1);
        enter0 = e0; exit0 = x0; enter1 = e1; exit1 = x1; reset = rst;
        @(posedge clk);
        model_step(e0, x0, e1, x1, rst);
        @(negedge clk);
        enter0 = 0; exit0 = 0; enter1 = 0; exit1 = 0; reset = 1'b1;
    endtask

    task automatic test_reset();
        tick(1, 1, 1, 1, 1'b0);
        tick(0, 0, 0, 0, 1'b0);
        n_checks++;
        if (obs !== exp_vec()) begin n_err++; $display("FAIL reset_model obs=%h exp=%h", obs, exp_vec()); end
        n_checks++;
        if ({inc, dec, count, full, empty, gate_ok, reject, overflow} !== {2'b00, 7'd0, 2'b01, 2'b11, 2'b00, 1'b0}) begin
            n_err++; $display("FAIL reset_values obs=%h exp=%h", obs, {2'b00, 7'd0, 2'b01, 2'b11, 2'b00, 1'b0});
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (inc !== 1'b0) begin n_err++; $display("FAIL reset_discard inc=%b exp=0", inc); end
    endtask

    task automatic test_single_enter();
        tick(1, 0, 0, 0);
        n_checks++;
        if (inc !== 1'b0) begin n_err++; $display("FAIL enter_early inc=%b exp=0", inc); end
        tick(0, 0, 0, 0);
        n_checks++;
        if ({inc, count, empty, gate_ok, reject} !== {1'b1, 7'd1, 1'b0, 2'b11, 2'b00}) begin
            n_err++; $display("FAIL enter_commit inc=%b count=%0d empty=%b gate=%b rej=%b exp 1/1/0/11/00", inc, count, empty, gate_ok, reject);
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (inc !== 1'b0 || obs !== exp_vec()) begin n_err++; $display("FAIL enter_oneshot obs=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_dual_enter();
        tick(0, 0, 0, 0, 1'b0);
        tick(1, 0, 1, 0);
        tick(0, 0, 0, 0);
        n_checks++;
        if ({inc, count} !== {1'b1, 7'd1}) begin n_err++; $display("FAIL dual_first inc=%b count=%0d exp 1/1", inc, count); end
        tick(0, 0, 0, 0);
        n_checks++;
        if ({inc, count} !== {1'b1, 7'd2}) begin n_err++; $display("FAIL dual_second inc=%b count=%0d exp 1/2", inc, count); end
        // Pointer now at 3: exit1 and enter0 together -> exit1 commits first, then enter0.
        tick(1, 0, 0, 1);
        tick(0, 0, 0, 0);
        n_checks++;
        if ({inc, dec, count} !== {1'b0, 1'b1, 7'd1}) begin n_err++; $display("FAIL dual_ptr3 inc=%b dec=%b count=%0d exp 0/1/1", inc, dec, count); end
        tick(0, 0, 0, 0);
        n_checks++;
        if (obs !== exp_vec()) begin n_err++; $display("FAIL dual_model obs=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_full();
        tick(0, 0, 0, 0, 1'b0);
        for (int i = 0; i < CAP; i++) begin
            tick(1, 0, 0, 0);
            tick(0, 0, 0, 0);
        end
        n_checks++;
        if ({count, full, gate_ok} !== {7'd5, 1'b1, 2'b00}) begin n_err++; $display("FAIL full_state count=%0d full=%b gate=%b exp 5/1/00", count, full, gate_ok); end
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        n_checks++;
        if ({inc, reject, count} !== {1'b0, 2'b10, 7'd5}) begin n_err++; $display("FAIL full_reject inc=%b rej=%b count=%0d exp 0/10/5", inc, reject, count); end
        tick(0, 0, 0, 0);
        n_checks++;
        if (reject !== 2'b00) begin n_err++; $display("FAIL full_reject_pulse rej=%b exp=00", reject); end
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        n_checks++;
        if ({dec, count, full, gate_ok} !== {1'b1, 7'd4, 1'b0, 2'b11}) begin n_err++; $display("FAIL full_exit dec=%b count=%0d full=%b gate=%b exp 1/4/0/11", dec, count, full, gate_ok); end
    endtask

    task automatic test_empty_reject();
        tick(0, 0, 0, 0, 1'b0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        n_checks++;
        if ({dec, reject, count, empty} !== {1'b0, 2'b10, 7'd0, 1'b1}) begin n_err++; $display("FAIL empty_reject dec=%b rej=%b count=%0d empty=%b exp 0/10/0/1", dec, reject, count, empty); end
    endtask

    task automatic test_overflow();
        int decs;
        tick(0, 0, 0, 0, 1'b0);
        tick(1, 1, 0, 0);
        tick(0, 1, 0, 0);
        n_checks++;
        if ({overflow, inc} !== 2'b11) begin n_err++; $display("FAIL ovf_set ovf=%b inc=%b exp 1/1", overflow, inc); end
        decs = 0;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0);
            decs += int'(dec);
        end
        n_checks++;
        if (decs !== 1) begin n_err++; $display("FAIL ovf_one_dec decs=%0d exp=1", decs); end
        n_checks++;
        if (overflow !== 1'b1 || obs !== exp_vec()) begin n_err++; $display("FAIL ovf_sticky obs=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_reset_mid_grant();
        tick(0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0);
            tick(0, 0, 0, 0);
        end
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0, 1'b0);
        n_checks++;
        if ({inc, count, empty, overflow} !== {1'b0, 7'd0, 1'b1, 1'b0}) begin n_err++; $display("FAIL midreset inc=%b count=%0d empty=%b ovf=%b exp 0/0/1/0", inc, count, empty, overflow); end
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        n_checks++;
        if ({inc, count} !== {1'b0, 7'd0}) begin n_err++; $display("FAIL midreset_flags inc=%b count=%0d exp 0/0", inc, count); end
    endtask

    task automatic test_random();
        bit p[4];
        bit r;
        for (int c = 0; c < 600; c++) begin
            foreach (p[i]) p[i] = ($urandom_range(0, 99) < 30);
            r = ($urandom_range(0, 199) != 0);
            tick(p[0], p[1], p[2], p[3], r);
            n_checks++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL random c=%0d obs=%h exp=%h", c, obs, exp_vec()); end
            n_checks++;
            if ((inc && dec) || reject == 2'b11) begin n_err++; $display("FAIL random_excl c=%0d inc=%b dec=%b rej=%b", c, inc, dec, reject); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_enter();
        test_dual_enter();
        test_full();
        test_empty_reject();
        test_overflow();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
